mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle main controller for the shared-memory MIPS datapath. It decodes the opcode held in the instruction register and drives the mux selects, register enables and memory requests one cycle-state at a time. It stalls on memory states until the memory acknowledges, and can be single-stepped from the debounced button. The top-level PC enable is PCwrite | (PCWriteCond & ALUzero).

Parameters:
USE_STEP, 0, 1: FSM advances only in cycles where step=1. 0: step is ignored (treated as 1).
HALT_ON_ILLEGAL, 1, 1: an unknown opcode enters HALT. 0: an unknown opcode pulses illegal and returns to FETCH as a NOP.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
opcode  in  6  instruction[31:26] from IR
step  in  1  single-step enable (debounced button level/pulse)
mem_ready  in  1  memory completed current MemRead/MemWrite request this cycle
PCwrite, PCWriteCond, IRwrite, RegWrite, MemRead, MemWrite  out  1 each  strobes/requests
IorD, ALUsrcA, RegDst, MemToReg  out  1 each  mux selects
ALUsrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 ext<<2
ALUop  out  2  00 add, 01 sub, 10 use funct
PCsrc  out  2  00 ALU result, 01 ALUout reg, 10 jump target
state  out  4  current state code (for display)
instr_done  out  1  1-cycle pulse on the final state of each instruction
illegal  out  1  1-cycle pulse when DECODE sees an unknown opcode
halted  out  1  high while in HALT

Behaviour:
- State register only; all outputs are Moore-decoded from state, with strobes qualified by adv. Unlisted outputs are 0.
- adv = step_eff & (mem_ready if state in {FETCH, MEM_RD, MEM_WR} else 1), where step_eff = step when USE_STEP=1, else 1.
- State transitions occur only when adv=1; otherwise the FSM holds its state and keeps selects/requests stable.
- Qualified strobes (asserted only when adv=1): PCwrite, PCWriteCond, IRwrite, RegWrite, instr_done.
- MemRead and MemWrite are level requests held for the whole state.
- Reset: while rst=0, all outputs are 0 and state is loaded with FETCH(0) at the clock edge. Reset mid-instruction abandons it with no further writes.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- FETCH 0: MemRead, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=00, PCsrc=00, IRwrite&PCwrite on adv. -> DECODE
- DECODE 1: ALUsrcA=0, ALUsrcB=11, ALUop=00 (branch target into ALUout).
  - lw/sw -> MEM_ADDR; R -> R_EXEC; beq -> BRANCH; j -> JUMP; addi -> I_EXEC.
  - Other opcodes: illegal pulse, then HALT (HALT_ON_ILLEGAL=1) or FETCH.
- MEM_ADDR 2: ALUsrcA=1, ALUsrcB=10, ALUop=00. lw -> MEM_RD, sw -> MEM_WR. Opcode is re-read from the stable IR.
- MEM_RD 3: MemRead, IorD=1. -> MEM_WB
- MEM_WB 4: RegDst=0, MemToReg=1, RegWrite. -> FETCH (instr_done)
- MEM_WR 5: MemWrite, IorD=1. -> FETCH on mem_ready (instr_done)
- R_EXEC 6: ALUsrcA=1, ALUsrcB=00, ALUop=10. -> R_WB
- R_WB 7: RegDst=1, MemToReg=0, RegWrite. -> FETCH (instr_done)
- BRANCH 8: ALUsrcA=1, ALUsrcB=00, ALUop=01, PCsrc=01, PCWriteCond. -> FETCH (instr_done)
- JUMP 9: PCsrc=10, PCwrite. -> FETCH (instr_done)
- I_EXEC 10: ALUsrcA=1, ALUsrcB=10, ALUop=00. -> I_WB
- I_WB 11: RegDst=0, MemToReg=0, RegWrite. -> FETCH (instr_done)
- HALT 15: halted=1, all else 0. Left only by reset.
- Unused codes 12-14 -> FETCH on the next edge, no strobes.
- Cycle counts with mem_ready=1 and step_eff=1: lw 5, sw 4, R/addi 4, beq/j 3.

Test Plan:
- rst=0 for 2 cycles with mem_ready=1 -> all outputs 0. After rst=1: state=0, MemRead=1, PCwrite=IRwrite=1 in the same cycle.
- R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0. ALUop=10 in state 6. RegWrite=1 and RegDst=1 in state 7, with instr_done pulse.
- lw with mem_ready held 0 for 3 cycles in MEM_RD -> state stays 3 with MemRead=1 and IorD=1, RegWrite never high. After ready: 4 then 0, RegWrite=1 with MemToReg=1.
- beq -> states 0,1,8,0. PCWriteCond=1 and PCsrc=01 for exactly one cycle. j -> PCwrite=1 with PCsrc=10.
- Opcode 111111 with HALT_ON_ILLEGAL=1 -> illegal pulse, state=15, halted=1 held for 20 cycles. rst=0 returns to state 0. With HALT_ON_ILLEGAL=0 -> back to 0.
- USE_STEP=1, step=0 in R_EXEC -> state frozen, no RegWrite. One-cycle step=1 -> exactly one transition.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: Moore-decoded control word per state, stalls on memory states.
// Latency: 3-5 cycles per instruction; holds state while step or mem_ready is low.
module mc_ctrl_fsm #(
  parameter int USE_STEP        = 0,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       step_i,
  input  logic       mem_ready_i,
  output logic       PCwrite_o,
  output logic       PCWriteCond_o,
  output logic       IRwrite_o,
  output logic       RegWrite_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IorD_o,
  output logic       ALUsrcA_o,
  output logic       RegDst_o,
  output logic       MemToReg_o,
  output logic [1:0] ALUsrcB_o,
  output logic [1:0] ALUop_o,
  output logic [1:0] PCsrc_o,
  output logic [3:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       halted_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state_q, state_d;
  logic   step_eff;
  logic   adv;

  assign step_eff = (USE_STEP != 0) ? step_i : 1'b1;
  assign adv      = step_eff & (((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR))
                                ? mem_ready_i : 1'b1);
  assign state_o  = rst_i ? state_q : FETCH;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    PCwrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IRwrite_o     = 1'b0;
    RegWrite_o    = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IorD_o        = 1'b0;
    ALUsrcA_o     = 1'b0;
    RegDst_o      = 1'b0;
    MemToReg_o    = 1'b0;
    ALUsrcB_o     = 2'b00;
    ALUop_o       = 2'b00;
    PCsrc_o       = 2'b00;
    instr_done_o  = 1'b0;
    illegal_o     = 1'b0;
    halted_o      = 1'b0;
    // Outputs stay quiet while reset is held, whatever the stale state register holds.
    if (rst_i) begin
      case (state_q)
        FETCH: begin
          MemRead_o = 1'b1;
          ALUsrcB_o = 2'b01;
          IRwrite_o = adv;
          PCwrite_o = adv;
          if (adv) state_d = DECODE;
        end
        DECODE: begin
          ALUsrcB_o = 2'b11;
          if (adv) begin
            case (opcode_i)
              OP_LW, OP_SW: state_d = MEM_ADDR;
              OP_R:         state_d = R_EXEC;
              OP_BEQ:       state_d = BRANCH;
              OP_J:         state_d = JUMP;
              OP_ADDI:      state_d = I_EXEC;
              default: begin
                illegal_o = 1'b1;
                state_d   = (HALT_ON_ILLEGAL != 0) ? HALT : FETCH;
              end
            endcase
          end
        end
        MEM_ADDR: begin
          ALUsrcA_o = 1'b1;
          ALUsrcB_o = 2'b10;
          if (adv) state_d = (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          MemRead_o = 1'b1;
          IorD_o    = 1'b1;
          if (adv) state_d = MEM_WB;
        end
        MEM_WB: begin
          MemToReg_o   = 1'b1;
          RegWrite_o   = adv;
          instr_done_o = adv;
          if (adv) state_d = FETCH;
        end
        MEM_WR: begin
          MemWrite_o   = 1'b1;
          IorD_o       = 1'b1;
          instr_done_o = adv;
          if (adv) state_d = FETCH;
        end
        R_EXEC: begin
          ALUsrcA_o = 1'b1;
          ALUop_o   = 2'b10;
          if (adv) state_d = R_WB;
        end
        R_WB: begin
          RegDst_o     = 1'b1;
          RegWrite_o   = adv;
          instr_done_o = adv;
          if (adv) state_d = FETCH;
        end
        BRANCH: begin
          ALUsrcA_o     = 1'b1;
          ALUop_o       = 2'b01;
          PCsrc_o       = 2'b01;
          PCWriteCond_o = adv;
          instr_done_o  = adv;
          if (adv) state_d = FETCH;
        end
        JUMP: begin
          PCsrc_o      = 2'b10;
          PCwrite_o    = adv;
          instr_done_o = adv;
          if (adv) state_d = FETCH;
        end
        I_EXEC: begin
          ALUsrcA_o = 1'b1;
          ALUsrcB_o = 2'b10;
          if (adv) state_d = I_WB;
        end
        I_WB: begin
          RegWrite_o   = adv;
          instr_done_o = adv;
          if (adv) state_d = FETCH;
        end
        HALT: halted_o = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: two configurations checked every cycle against an instruction-path model.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mem_ready, step1;
  logic [5:0] opc0, opc1;
  wire  [22:0] obs0, obs1;

  mc_ctrl_fsm #(.USE_STEP(0), .HALT_ON_ILLEGAL(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .opcode_i(opc0), .step_i(1'b0), .mem_ready_i(mem_ready),
    .PCwrite_o(obs0[22]), .PCWriteCond_o(obs0[21]), .IRwrite_o(obs0[20]), .RegWrite_o(obs0[19]),
    .MemRead_o(obs0[18]), .MemWrite_o(obs0[17]), .IorD_o(obs0[16]), .ALUsrcA_o(obs0[15]),
    .RegDst_o(obs0[14]), .MemToReg_o(obs0[13]), .ALUsrcB_o(obs0[12:11]), .ALUop_o(obs0[10:9]),
    .PCsrc_o(obs0[8:7]), .state_o(obs0[6:3]), .instr_done_o(obs0[2]), .illegal_o(obs0[1]),
    .halted_o(obs0[0]));

  mc_ctrl_fsm #(.USE_STEP(1), .HALT_ON_ILLEGAL(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .opcode_i(opc1), .step_i(step1), .mem_ready_i(mem_ready),
    .PCwrite_o(obs1[22]), .PCWriteCond_o(obs1[21]), .IRwrite_o(obs1[20]), .RegWrite_o(obs1[19]),
    .MemRead_o(obs1[18]), .MemWrite_o(obs1[17]), .IorD_o(obs1[16]), .ALUsrcA_o(obs1[15]),
    .RegDst_o(obs1[14]), .MemToReg_o(obs1[13]), .ALUsrcB_o(obs1[12:11]), .ALUop_o(obs1[10:9]),
    .PCsrc_o(obs1[8:7]), .state_o(obs1[6:3]), .instr_done_o(obs1[2]), .illegal_o(obs1[1]),
    .halted_o(obs1[0]));

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Model: each instruction is FETCH followed by a fixed path of states chosen by its opcode.
  logic [5:0] mop [2];
  logic [5:0] nxt [2];
  int         midx [2];

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  function automatic int path_len(input logic [5:0] op, input int d);
    case (op)
      6'b100011: return 4;
      6'b101011, 6'b000000, 6'b001000: return 3;
      6'b000100, 6'b000010: return 2;
      default: return (d == 0) ? 2 : 1;
    endcase
  endfunction

  function automatic int path_at(input logic [5:0] op, input int k);
    int p [4];
    p = '{1, 15, 0, 0};
    case (op)
      6'b100011: p = '{1, 2, 3, 4};
      6'b101011: p = '{1, 2, 5, 0};
      6'b000000: p = '{1, 6, 7, 0};
      6'b001000: p = '{1, 10, 11, 0};
      6'b000100: p = '{1, 8, 0, 0};
      6'b000010: p = '{1, 9, 0, 0};
      default: ;
    endcase
    return p[k-1];
  endfunction

  function automatic int cur_state(input int d);
    return (midx[d] == 0) ? 0 : path_at(mop[d], midx[d]);
  endfunction

  function automatic logic [22:0] exp_vec(input int st, input logic [5:0] op,
                                          input bit adv, input bit r);
    logic [22:0] v;
    v = '0;
    if (!r) return v;
    v[6:3] = 4'(st);
    case (st)
      0:  begin v[18] = 1; v[12:11] = 2'b01; v[20] = adv; v[22] = adv; end
      1:  begin v[12:11] = 2'b11; v[1] = adv && !legal(op); end
      2:  begin v[15] = 1; v[12:11] = 2'b10; end
      3:  begin v[18] = 1; v[16] = 1; end
      4:  begin v[13] = 1; v[19] = adv; v[2] = adv; end
      5:  begin v[17] = 1; v[16] = 1; v[2] = adv; end
      6:  begin v[15] = 1; v[10:9] = 2'b10; end
      7:  begin v[14] = 1; v[19] = adv; v[2] = adv; end
      8:  begin v[15] = 1; v[10:9] = 2'b01; v[8:7] = 2'b01; v[21] = adv; v[2] = adv; end
      9:  begin v[8:7] = 2'b10; v[22] = adv; v[2] = adv; end
      10: begin v[15] = 1; v[12:11] = 2'b10; end
      11: begin v[19] = adv; v[2] = adv; end
      15: v[0] = 1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic cyc(input bit r, input bit mr, input bit s);
    @(negedge clk);
    rst = r; mem_ready = mr; step1 = s;
    opc0 = mop[0]; opc1 = mop[1];
    #1;
    for (int d = 0; d < 2; d++) begin
      int          st;
      bit          adv;
      logic [22:0] e, o;
      st  = cur_state(d);
      adv = ((d == 1) ? s : 1'b1) && ((st == 0 || st == 3 || st == 5) ? mr : 1'b1);
      e   = exp_vec(st, mop[d], adv, r);
      o   = (d == 0) ? obs0 : obs1;
      checks++;
      assert (o === e) else begin
        failures++;
        $error("FAIL dut%0d cycle %0d observed=%h expected=%h", d, cycle, o, e);
      end
      if (!r) midx[d] = 0;
      else if (st == 15) midx[d] = midx[d];
      else if (adv) begin
        if (midx[d] == 0) begin
          mop[d]  = nxt[d];
          midx[d] = 1;
        end else if (midx[d] >= path_len(mop[d], d)) midx[d] = 0;
        else midx[d] = midx[d] + 1;
      end
    end
    cycle++;
  endtask

  task automatic run(input int n, input bit mr, input bit s);
    for (int i = 0; i < n; i++) cyc(1'b1, mr, s);
  endtask

  task automatic set_op(input logic [5:0] op);
    nxt[0] = op; nxt[1] = op;
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    rst = 1'b0; mem_ready = 1'b1; step1 = 1'b1; opc0 = '0; opc1 = '0;
    mop[0] = '0; mop[1] = '0; midx[0] = 0; midx[1] = 0;
    set_op(6'b000000);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    set_op(6'b000000); run(4, 1'b1, 1'b1);
    set_op(6'b100011); run(3, 1'b1, 1'b1); run(3, 1'b0, 1'b1); run(2, 1'b1, 1'b1);
    set_op(6'b101011); run(4, 1'b1, 1'b1);
    set_op(6'b000100); run(3, 1'b1, 1'b1);
    set_op(6'b000010); run(3, 1'b1, 1'b1);
    set_op(6'b001000); run(4, 1'b1, 1'b1);
    set_op(6'b111111); run(22, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    set_op(6'b000000);
    run(2, 1'b1, 1'b1); run(3, 1'b1, 1'b0); run(1, 1'b1, 1'b1); run(2, 1'b1, 1'b0);
    run(2, 1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 19) < 2) nxt[d] = 6'($urandom_range(0, 63));
        else nxt[d] = legal_ops[$urandom_range(0, 5)];
      end
      cyc($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
